// File: rtl/controlador_lcd.sv
// rtl/controlador_lcd.sv - HD44780 16x2 LCD controller: power-on init, then continuous "Tiempo: CDUs" refresh
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active high
//   mostrar_cen  hundreds character word {RS, byte}
//   mostrar_dec  tens character word {RS, byte}
//   mostrar_uni  units character word {RS, byte}
//   rs           LCD register select (word bit 8)
//   rw           LCD read/write, always write (0)
//   en           LCD enable strobe
//   data         LCD 8-bit data bus (word bits 7:0)
//   listo        high once the init sequence has completed
//   trama        one-cycle pulse at the end of every refresh frame
//
// Every word is written with the same three phases: SETUP (1 cycle, bus
// changes, en low), STROBE (EN_CYC cycles, en high), HOLD (CMD_CYC cycles,
// or CLR_CYC after the clear-display command). All outputs are registered.

module controlador_lcd #(
    parameter int PWR_CYC = 1_000_000,
    parameter int EN_CYC  = 25,
    parameter int CMD_CYC = 2_000,
    parameter int CLR_CYC = 82_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] mostrar_cen,
    input  logic [8:0] mostrar_dec,
    input  logic [8:0] mostrar_uni,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] data,
    output logic       listo,
    output logic       trama
);

    // One shared wait counter sized for the longest wait of any kind.
    localparam int MAX_AB  = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int MAX_CD  = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

    localparam logic [8:0] CMD_CLEAR  = 9'h001;
    localparam logic [8:0] CMD_LINE1  = 9'h080;
    localparam logic [3:0] INIT_LAST  = 4'd3;
    localparam logic [3:0] FRAME_LAST = 4'd12;

    typedef enum logic [1:0] {
        PWR_WAIT = 2'd0,
        INIT     = 2'd1,
        FRAME    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SETUP  = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } phase_t;

    state_t           state;
    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [3:0]       idx_next;
    logic [CNT_W-1:0] hold_last;

    // Digit snapshot taken at the start of each frame so a frame never mixes
    // old and new digits.
    logic [8:0] snap_cen;
    logic [8:0] snap_dec;
    logic [8:0] snap_uni;

    assign rw       = 1'b0;
    assign idx_next = idx + 4'd1;

    // The word currently on the bus decides how long its HOLD lasts.
    assign hold_last = ({rs, data} == CMD_CLEAR) ? CLR_LAST : CMD_LAST;

    function automatic logic [8:0] init_word(input logic [3:0] i);
        logic [8:0] w;
        case (i)
            4'd0:    w = 9'h038;  // 8-bit bus, 2 lines, 5x8 font
            4'd1:    w = 9'h00C;  // display on, cursor off
            4'd2:    w = 9'h006;  // entry mode: increment, no shift
            default: w = 9'h001;  // clear display
        endcase
        return w;
    endfunction

    function automatic logic [8:0] frame_word(
        input logic [3:0] i,
        input logic [8:0] c,
        input logic [8:0] d,
        input logic [8:0] u
    );
        logic [8:0] w;
        case (i)
            4'd0:    w = CMD_LINE1;
            4'd1:    w = 9'h154;  // 'T'
            4'd2:    w = 9'h169;  // 'i'
            4'd3:    w = 9'h165;  // 'e'
            4'd4:    w = 9'h16D;  // 'm'
            4'd5:    w = 9'h170;  // 'p'
            4'd6:    w = 9'h16F;  // 'o'
            4'd7:    w = 9'h13A;  // ':'
            4'd8:    w = 9'h120;  // ' '
            4'd9:    w = c;
            4'd10:   w = d;
            4'd11:   w = u;
            default: w = 9'h173;  // 's'
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PWR_WAIT;
            phase    <= SETUP;
            cnt      <= '0;
            idx      <= '0;
            rs       <= 1'b0;
            data     <= 8'h00;
            en       <= 1'b0;
            listo    <= 1'b0;
            trama    <= 1'b0;
            snap_cen <= 9'h130;
            snap_dec <= 9'h130;
            snap_uni <= 9'h130;
        end else begin
            trama <= 1'b0;

            case (state)
                PWR_WAIT: begin
                    en <= 1'b0;
                    if (cnt == PWR_LAST) begin
                        cnt          <= '0;
                        state        <= INIT;
                        phase        <= SETUP;
                        idx          <= '0;
                        {rs, data}   <= init_word(4'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                INIT, FRAME: begin
                    case (phase)
                        SETUP: begin
                            phase <= STROBE;
                            en    <= 1'b1;
                            cnt   <= '0;
                        end

                        STROBE: begin
                            if (cnt == EN_LAST) begin
                                phase <= HOLD;
                                en    <= 1'b0;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end

                        HOLD: begin
                            if (cnt == hold_last) begin
                                cnt   <= '0;
                                phase <= SETUP;
                                if (state == INIT) begin
                                    if (idx == INIT_LAST) begin
                                        // Init done: first frame starts right away.
                                        state      <= FRAME;
                                        listo      <= 1'b1;
                                        idx        <= '0;
                                        {rs, data} <= CMD_LINE1;
                                        snap_cen   <= mostrar_cen;
                                        snap_dec   <= mostrar_dec;
                                        snap_uni   <= mostrar_uni;
                                    end else begin
                                        idx        <= idx_next;
                                        {rs, data} <= init_word(idx_next);
                                    end
                                end else begin
                                    if (idx == FRAME_LAST) begin
                                        // Frame complete: flag it and restart at line 1.
                                        trama      <= 1'b1;
                                        idx        <= '0;
                                        {rs, data} <= CMD_LINE1;
                                        snap_cen   <= mostrar_cen;
                                        snap_dec   <= mostrar_dec;
                                        snap_uni   <= mostrar_uni;
                                    end else begin
                                        idx        <= idx_next;
                                        {rs, data} <= frame_word(idx_next, snap_cen,
                                                                 snap_dec, snap_uni);
                                    end
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end

                        default: begin
                            phase <= SETUP;
                            en    <= 1'b0;
                            cnt   <= '0;
                        end
                    endcase
                end

                default: begin
                    state <= PWR_WAIT;
                    phase <= SETUP;
                    en    <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_lcd.sv
// tb/tb_controlador_lcd.sv - directed self-checking bench for controlador_lcd

module tb_controlador_lcd;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] mostrar_cen;
    logic [8:0] mostrar_dec;
    logic [8:0] mostrar_uni;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] data;
    logic       listo;
    logic       trama;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_t = 0;

    always #5 clk = ~clk;

    controlador_lcd #(
        .PWR_CYC(10),
        .EN_CYC (2),
        .CMD_CYC(4),
        .CLR_CYC(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mostrar_cen(mostrar_cen),
        .mostrar_dec(mostrar_dec),
        .mostrar_uni(mostrar_uni),
        .rs         (rs),
        .rw         (rw),
        .en         (en),
        .data       (data),
        .listo      (listo),
        .trama      (trama)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
        end
    endtask

    // Advance to sample point t (negedge of the cycle following edge t).
    task automatic goto(input int t);
        while (cur_t < t) begin
            @(negedge clk);
            cur_t++;
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
        cur_t = -1;
        goto(0);
    endtask

    task automatic power_on_check();
        for (int t = 0; t < 10; t++) begin
            goto(t);
            chk("pwr_en_low", 9'(en), 9'h0);
        end
        goto(10);
        chk("pwr_first_word", {rs, data}, 9'h038);
        chk("pwr_first_en", 9'(en), 9'h0);
        chk("pwr_rw", 9'(rw), 9'h0);
        goto(11);
        chk("pwr_strobe1", 9'(en), 9'h1);
        goto(12);
        chk("pwr_strobe2", 9'(en), 9'h1);
        goto(13);
        chk("pwr_hold", 9'(en), 9'h0);
    endtask

    task automatic chk_word(input string tag, input int t, input logic [8:0] exp);
        goto(t);
        chk(tag, {rs, data}, exp);
        chk({tag, "_setup_en"}, 9'(en), 9'h0);
        goto(t + 1);
        chk({tag, "_strobe_en"}, 9'(en), 9'h1);
    endtask

    // One frame starting at t0; optionally changes inputs during the ':' write.
    task automatic chk_frame(input int t0, input logic exp_trama,
                             input logic [8:0] c, input logic [8:0] d, input logic [8:0] u,
                             input logic chg,
                             input logic [8:0] nc, input logic [8:0] nd, input logic [8:0] nu);
        logic [8:0] exp_f [13];
        exp_f[0]  = 9'h080;
        exp_f[1]  = 9'h154;
        exp_f[2]  = 9'h169;
        exp_f[3]  = 9'h165;
        exp_f[4]  = 9'h16D;
        exp_f[5]  = 9'h170;
        exp_f[6]  = 9'h16F;
        exp_f[7]  = 9'h13A;
        exp_f[8]  = 9'h120;
        exp_f[9]  = c;
        exp_f[10] = d;
        exp_f[11] = u;
        exp_f[12] = 9'h173;
        goto(t0);
        chk("frame_trama_start", 9'(trama), 9'(exp_trama));
        chk("frame_listo", 9'(listo), 9'h1);
        for (int k = 0; k < 13; k++) begin
            chk_word($sformatf("frame_w%0d", k), t0 + 7 * k, exp_f[k]);
            if (k == 0)
                chk("frame_trama_cleared", 9'(trama), 9'h0);
            if (k == 7 && chg) begin
                mostrar_cen = nc;
                mostrar_dec = nd;
                mostrar_uni = nu;
            end
        end
        goto(t0 + 90);
        chk("frame_trama_before_end", 9'(trama), 9'h0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        mostrar_cen = 9'h131;
        mostrar_dec = 9'h134;
        mostrar_uni = 9'h137;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rs", 9'(rs), 9'h0);
        chk("rst_en", 9'(en), 9'h0);
        chk("rst_data", 9'(data), 9'h0);
        chk("rst_listo", 9'(listo), 9'h0);
        chk("rst_trama", 9'(trama), 9'h0);
        chk("rst_rw", 9'(rw), 9'h0);

        release_rst();
        power_on_check();

        // Init sequence
        chk_word("init_00C", 17, 9'h00C);
        chk_word("init_006", 24, 9'h006);
        chk_word("init_001", 31, 9'h001);
        goto(41);
        chk("init_listo_low", 9'(listo), 9'h0);
        chk("init_clear_hold", {rs, data}, 9'h001);
        chk("init_clear_en", 9'(en), 9'h0);
        goto(42);
        chk("init_listo_high", 9'(listo), 9'h1);
        chk("init_line1", {rs, data}, 9'h080);

        // Frame 1: digits 1,4,7; inputs change to 9,9,9 during ':'
        chk_frame(42, 1'b0, 9'h131, 9'h134, 9'h137, 1'b1, 9'h139, 9'h139, 9'h139);
        // Frame 2: digits 9,9,9; units input becomes invalid 9'h000 during ':'
        chk_frame(133, 1'b1, 9'h139, 9'h139, 9'h139, 1'b1, 9'h139, 9'h139, 9'h000);
        // Frame 3: invalid units word passes through unchanged
        chk_frame(224, 1'b1, 9'h139, 9'h139, 9'h000, 1'b0, 9'h000, 9'h000, 9'h000);

        // Frame 4 start, then reset in the middle of the strobe
        goto(315);
        chk("f4_trama", 9'(trama), 9'h1);
        chk("f4_line1", {rs, data}, 9'h080);
        goto(316);
        chk("f4_strobe", 9'(en), 9'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 9'(en), 9'h0);
        chk("async_rst_rs", 9'(rs), 9'h0);
        chk("async_rst_data", 9'(data), 9'h0);
        chk("async_rst_listo", 9'(listo), 9'h0);
        repeat (2) @(posedge clk);
        release_rst();
        power_on_check();
        chk_word("rerun_00C", 17, 9'h00C);
        goto(41);
        chk("rerun_listo_low", 9'(listo), 9'h0);
        goto(42);
        chk("rerun_listo_high", 9'(listo), 9'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
